// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined carry-lookahead subtractor: d = a - b - bin, split at SPLIT.
// The low half resolves in stage 1 and the high half in stage 2, with valid/ready on both ends.
module cla_subtractor_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int HI = WIDTH - SPLIT;

  logic             s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0] s1_lo_q, s1_lo_d;
  logic             s1_c_q, s1_c_d;
  logic [HI-1:0]    s1_a_hi_q, s1_a_hi_d;
  logic [HI-1:0]    s1_nb_hi_q, s1_nb_hi_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic s2_free, s2_load, accept;

  logic [SPLIT-1:0] lo_p, lo_g, lo_pp, lo_gg, lo_diff;
  logic [SPLIT:0]   lo_c;
  logic [HI-1:0]    hi_p, hi_g, hi_pp, hi_gg, hi_diff;
  logic [HI:0]      hi_c;

  // Kogge-Stone prefix over the low half; carry-in is the inverted borrow-in.
  always_comb begin
    lo_p  = a[SPLIT-1:0] ^ ~b[SPLIT-1:0];
    lo_g  = a[SPLIT-1:0] & ~b[SPLIT-1:0];
    lo_pp = lo_p;
    lo_gg = lo_g;
    lo_gg[0] = lo_g[0] | (lo_p[0] & ~bin);
    for (int k = 1; k < SPLIT; k = k * 2) begin
      for (int i = SPLIT - 1; i >= k; i--) begin
        lo_gg[i] = lo_gg[i] | (lo_pp[i] & lo_gg[i-k]);
        lo_pp[i] = lo_pp[i] & lo_pp[i-k];
      end
    end
    lo_c    = {lo_gg, ~bin};
    lo_diff = lo_p ^ lo_c[SPLIT-1:0];
  end

  // Same prefix for the high half, fed by the carry registered at the cut.
  always_comb begin
    hi_p  = s1_a_hi_q ^ s1_nb_hi_q;
    hi_g  = s1_a_hi_q & s1_nb_hi_q;
    hi_pp = hi_p;
    hi_gg = hi_g;
    hi_gg[0] = hi_g[0] | (hi_p[0] & s1_c_q);
    for (int k = 1; k < HI; k = k * 2) begin
      for (int i = HI - 1; i >= k; i--) begin
        hi_gg[i] = hi_gg[i] | (hi_pp[i] & hi_gg[i-k]);
        hi_pp[i] = hi_pp[i] & hi_pp[i-k];
      end
    end
    hi_c    = {hi_gg, s1_c_q};
    hi_diff = hi_p ^ hi_c[HI-1:0];
  end

  always_comb begin
    s2_free  = ~out_valid_q | out_ready;
    s2_load  = s1_valid_q & s2_free;
    in_ready = ~s1_valid_q | s2_free;
    accept   = in_valid & in_ready;

    s1_valid_d = accept | (s1_valid_q & ~s2_load);
    s1_lo_d    = s1_lo_q;
    s1_c_d     = s1_c_q;
    s1_a_hi_d  = s1_a_hi_q;
    s1_nb_hi_d = s1_nb_hi_q;
    if (accept) begin
      s1_lo_d    = lo_diff;
      s1_c_d     = lo_c[SPLIT];
      s1_a_hi_d  = a[WIDTH-1:SPLIT];
      s1_nb_hi_d = ~b[WIDTH-1:SPLIT];
    end

    // A full, unconsumed output register holds until the consumer takes it.
    out_valid_d = s2_load | (out_valid_q & ~out_ready);
    d_d         = d_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    if (s2_load) begin
      d_d    = {hi_diff, s1_lo_q};
      bout_d = ~hi_c[HI];
      ovf_d  = hi_c[HI] ^ hi_c[HI-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_c_q      <= 1'b0;
      s1_a_hi_q   <= '0;
      s1_nb_hi_q  <= '0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_c_q      <= s1_c_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s1_nb_hi_q  <= s1_nb_hi_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Scoreboard bench for cla_subtractor_pipe: stimulus pushes expected results,
// an independent monitor pops and compares whenever an output is handed off.
module tb_cla_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        bout;
  logic        ovf;

  typedef struct packed {
    logic [31:0] d;
    logic        bout;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  res_t mon_exp;
  int   checks = 0;
  int   errors = 0;

  cla_subtractor_pipe #(.WIDTH(32), .SPLIT(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: wide unsigned arithmetic for d/bout, true signed range test for ovf.
  function automatic res_t referenceModel(input logic [31:0] ia, input logic [31:0] ib, input logic ibin);
    res_t        r;
    logic [32:0] u;
    longint      s;
    u = {1'b0, ia} - {1'b0, ib} - {32'd0, ibin};
    s = longint'($signed(ia)) - longint'($signed(ib)) - longint'({63'd0, ibin});
    r.d    = u[31:0];
    r.bout = u[32];
    r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic driveNow(input logic v, input logic [31:0] ia, input logic [31:0] ib, input logic ibin,
                          input logic ordy, input res_t expv, output logic acc);
    in_valid  = v;
    a         = ia;
    b         = ib;
    bin       = ibin;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) exp_q.push_back(expv);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ia, input logic [31:0] ib, input logic ibin,
                               input logic ordy, input res_t expv, output logic acc);
    @(negedge clk);
    driveNow(v, ia, ib, ibin, ordy, expv, acc);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0, acc);
  endtask

  // Monitor: every handshake on the output must match the oldest expected result.
  always @(negedge clk) begin
    #3;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got d=0x%0h with nothing outstanding at %0t", d, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("result", {30'd0, d, bout, ovf}, {30'd0, mon_exp});
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        acc;
    logic [31:0] va[6];
    logic [31:0] vb[6];
    logic        vbin[6];
    res_t        vexp[6];
    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];
    int          idx;
    int          issued;
    int          cyc;
    logic        v, ordy, rbin;
    logic [31:0] ra, rb;

    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset_outputs", {30'd0, out_valid, d, bout, ovf}, 64'd0);

    // First acceptance on the first rising edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    driveNow(1'b1, 32'd5, 32'd3, 1'b0, 1'b1, '{d: 32'd2, bout: 1'b0, ovf: 1'b0}, acc);
    checkOutput("first_accept", {63'd0, acc}, 64'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0, acc);
    checkOutput("latency_cycle1", {63'd0, out_valid}, 64'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0, acc);
    checkOutput("latency_cycle2", {30'd0, out_valid, d, bout, ovf}, {30'd0, 1'b1, 32'd2, 1'b0, 1'b0});
    idle(2);

    // Directed flag and split-crossing vectors with spec-given results.
    va   = '{32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h12345678, 32'h00010000, 32'hFFFFFFFF};
    vb   = '{32'h1, 32'h1,        32'hFFFFFFFF, 32'h12345678, 32'h1,        32'hFFFFFFFF};
    vbin = '{1'b0,  1'b0,         1'b0,         1'b1,         1'b0,         1'b0};
    vexp = '{'{d: 32'hFFFFFFFF, bout: 1'b1, ovf: 1'b0},
             '{d: 32'h7FFFFFFF, bout: 1'b0, ovf: 1'b1},
             '{d: 32'h80000000, bout: 1'b1, ovf: 1'b1},
             '{d: 32'hFFFFFFFF, bout: 1'b1, ovf: 1'b0},
             '{d: 32'h0000FFFF, bout: 1'b0, ovf: 1'b0},
             '{d: 32'h00000000, bout: 1'b0, ovf: 1'b0}};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, va[i], vb[i], vbin[i], 1'b1, vexp[i], acc);
      checkOutput("directed_accept", {63'd0, acc}, 64'd1);
    end
    idle(4);

    // Backpressure: consumer stalled for five cycles with input held valid.
    bp_a = '{32'd10, 32'd20, 32'd30, 32'd40};
    bp_b = '{32'd1, 32'd2, 32'd3, 32'd4};
    idx  = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, bp_a[idx], bp_b[idx], 1'b0, 1'b0,
                    '{d: 32'(9 * (idx + 1)), bout: 1'b0, ovf: 1'b0}, acc);
      if (acc) idx++;
      if (c >= 2) begin
        checkOutput("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        checkOutput("bp_hold", {31'd0, out_valid, d}, {31'd0, 1'b1, 32'd9});
      end
    end
    checkOutput("bp_accepted", 64'(idx), 64'd2);
    for (int c = 0; c < 4; c++) begin
      v = (idx < 4);
      applyStimulus(v, v ? bp_a[idx] : 32'd0, v ? bp_b[idx] : 32'd0, 1'b0, 1'b1,
                    '{d: 32'(9 * (idx + 1)), bout: 1'b0, ovf: 1'b0}, acc);
      if (acc) idx++;
      checkOutput("bp_stream", {31'd0, out_valid, d}, {31'd0, 1'b1, 32'(9 * (c + 1))});
    end
    checkOutput("bp_all_accepted", 64'(idx), 64'd4);
    idle(3);

    // Randomized streaming with random valid/ready and corner-biased operands.
    issued = 0;
    cyc    = 0;
    while (issued < 1000 && cyc < 20000) begin
      v    = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 7))
        0: ra = 32'h0;
        1: ra = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: ra = 32'h00010000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'h7FFFFFFF;
        3: rb = 32'h1;
        default: rb = $urandom;
      endcase
      rbin = 1'($urandom_range(0, 1));
      applyStimulus(v, ra, rb, rbin, ordy, referenceModel(ra, rb, rbin), acc);
      if (acc) issued++;
      cyc++;
    end
    checkOutput("random_issued", 64'(issued), 64'd1000);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) idle(1);
    idle(1);
    checkOutput("random_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two transactions in flight: both must vanish.
    applyStimulus(1'b1, 32'd100, 32'd1, 1'b0, 1'b0, '{d: 32'd99, bout: 1'b0, ovf: 1'b0}, acc);
    applyStimulus(1'b1, 32'd200, 32'd1, 1'b0, 1'b0, '{d: 32'd199, bout: 1'b0, ovf: 1'b0}, acc);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("rst_clears_out", {31'd0, out_valid, d}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    applyStimulus(1'b1, 32'h00010000, 32'd1, 1'b0, 1'b1, '{d: 32'h0000FFFF, bout: 1'b0, ovf: 1'b0}, acc);
    checkOutput("post_rst_accept", {63'd0, acc}, 64'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0, acc);
    checkOutput("post_rst_cycle1", {63'd0, out_valid}, 64'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0, acc);
    checkOutput("post_rst_cycle2", {31'd0, out_valid, d}, {31'd0, 1'b1, 32'h0000FFFF});
    idle(3);
    checkOutput("final_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
